// File: rtl/control_unit.sv
// RV32I decode-stage control unit: combinational opcode/funct decode into a
// 16-bit control bundle, registered once so every field is valid one clock later.
module control_unit (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] instruction,
    output logic [15:0] control_signals,
    output logic        illegal
);

    typedef enum logic [3:0] {
        ALU_ADD    = 4'b0000,
        ALU_SUB    = 4'b0001,
        ALU_AND    = 4'b0010,
        ALU_OR     = 4'b0011,
        ALU_XOR    = 4'b0100,
        ALU_SLL    = 4'b0101,
        ALU_SRL    = 4'b0110,
        ALU_SRA    = 4'b0111,
        ALU_SLT    = 4'b1000,
        ALU_SLTU   = 4'b1001,
        ALU_PASS_B = 4'b1010
    } alu_op_e;

    typedef enum logic [2:0] {
        IMM_I = 3'b000,
        IMM_S = 3'b001,
        IMM_B = 3'b010,
        IMM_J = 3'b011,
        IMM_U = 3'b100
    } imm_type_e;

    typedef enum logic [1:0] {
        PC_PLUS4 = 2'b00,
        PC_JAL   = 2'b01,
        PC_JALR  = 2'b10
    } pc_src_e;

    typedef enum logic [6:0] {
        OP_R      = 7'b0110011,
        OP_IMM    = 7'b0010011,
        OP_LOAD   = 7'b0000011,
        OP_STORE  = 7'b0100011,
        OP_BRANCH = 7'b1100011,
        OP_JAL    = 7'b1101111,
        OP_JALR   = 7'b1100111,
        OP_LUI    = 7'b0110111
    } opcode_e;

    localparam logic [6:0] F7_ZERO = 7'b0000000;
    localparam logic [6:0] F7_ALT  = 7'b0100000;

    logic [6:0] opcode;
    logic [2:0] funct3;
    logic [6:0] funct7;
    logic       unused_fields;

    logic       reg_write, mem_to_reg, mem_read, mem_write;
    logic       branch, jump, alu_src, bad;
    alu_op_e    alu_op;
    imm_type_e  imm_type;
    pc_src_e    pc_src;
    logic [15:0] next_ctrl;

    assign opcode = instruction[6:0];
    assign funct3 = instruction[14:12];
    assign funct7 = instruction[31:25];
    // Register specifiers never influence decode.
    assign unused_fields = ^{instruction[24:15], instruction[11:7]};

    function automatic alu_op_e alu_from_funct3(input logic [2:0] f3, input logic alt);
        case (f3)
            3'b000:  return alt ? ALU_SUB : ALU_ADD;
            3'b001:  return ALU_SLL;
            3'b010:  return ALU_SLT;
            3'b011:  return ALU_SLTU;
            3'b100:  return ALU_XOR;
            3'b101:  return alt ? ALU_SRA : ALU_SRL;
            3'b110:  return ALU_OR;
            default: return ALU_AND;
        endcase
    endfunction

    always_comb begin
        reg_write  = 1'b0;
        mem_to_reg = 1'b0;
        mem_read   = 1'b0;
        mem_write  = 1'b0;
        branch     = 1'b0;
        jump       = 1'b0;
        alu_src    = 1'b0;
        alu_op     = ALU_ADD;
        imm_type   = IMM_I;
        pc_src     = PC_PLUS4;
        bad        = 1'b0;

        case (opcode)
            OP_R: begin
                reg_write = 1'b1;
                alu_op    = alu_from_funct3(funct3, funct7 == F7_ALT);
                if (!(funct7 == F7_ZERO ||
                      (funct7 == F7_ALT && (funct3 == 3'b000 || funct3 == 3'b101))))
                    bad = 1'b1;
            end
            OP_IMM: begin
                reg_write = 1'b1;
                alu_src   = 1'b1;
                // Upper immediate bits only select SRAI; ADDI with bit30 set stays ADD.
                alu_op    = alu_from_funct3(funct3, funct3 == 3'b101 && funct7 == F7_ALT);
                if (funct3 == 3'b001 && funct7 != F7_ZERO)
                    bad = 1'b1;
                if (funct3 == 3'b101 && funct7 != F7_ZERO && funct7 != F7_ALT)
                    bad = 1'b1;
            end
            OP_LOAD: begin
                reg_write  = 1'b1;
                mem_to_reg = 1'b1;
                mem_read   = 1'b1;
                alu_src    = 1'b1;
                if (funct3 == 3'b011 || funct3 == 3'b110 || funct3 == 3'b111)
                    bad = 1'b1;
            end
            OP_STORE: begin
                mem_write = 1'b1;
                alu_src   = 1'b1;
                imm_type  = IMM_S;
                if (funct3[2] || funct3 == 3'b011)
                    bad = 1'b1;
            end
            OP_BRANCH: begin
                branch   = 1'b1;
                imm_type = IMM_B;
                case (funct3[2:1])
                    2'b00:   alu_op = ALU_SUB;
                    2'b10:   alu_op = ALU_SLT;
                    2'b11:   alu_op = ALU_SLTU;
                    default: bad    = 1'b1;
                endcase
            end
            OP_JAL: begin
                reg_write = 1'b1;
                jump      = 1'b1;
                imm_type  = IMM_J;
                pc_src    = PC_JAL;
            end
            OP_JALR: begin
                reg_write = 1'b1;
                jump      = 1'b1;
                alu_src   = 1'b1;
                pc_src    = PC_JALR;
                if (funct3 != 3'b000)
                    bad = 1'b1;
            end
            OP_LUI: begin
                reg_write = 1'b1;
                alu_src   = 1'b1;
                alu_op    = ALU_PASS_B;
                imm_type  = IMM_U;
            end
            default: bad = 1'b1;
        endcase

        // Illegal encodings collapse to a NOP so no side-effect bit can leak out.
        if (bad)
            next_ctrl = '0;
        else
            next_ctrl = {pc_src, imm_type, alu_op, alu_src, jump, branch,
                         mem_write, mem_read, mem_to_reg, reg_write};
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            control_signals <= '0;
            illegal         <= 1'b0;
        end else begin
            control_signals <= next_ctrl;
            illegal         <= bad;
        end
    end

endmodule

// File: tb/tb_control_unit.sv
// Randomized self-checking bench for control_unit against a table-driven
// behavioural decode model, plus literal bundles pinning the model itself.
module tb_control_unit;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] instruction;
    logic [15:0] control_signals;
    logic        illegal;

    int checks = 0;
    int errors = 0;

    logic [15:0] exp_ctrl  = '0;
    logic        exp_ill   = 1'b0;
    logic        exp_valid = 1'b0;
    logic [31:0] exp_instr = '0;

    control_unit dut (
        .clk(clk),
        .rst(rst),
        .instruction(instruction),
        .control_signals(control_signals),
        .illegal(illegal)
    );

    always #5 clk = ~clk;

    // Bundle built from named fields with place-value arithmetic.
    function automatic void model(input logic [31:0] ins, output logic [15:0] c, output logic il);
        int alu_map[8];
        int br_map[8];
        int op, f3, f7;
        int rw, mtr, mr, mw, br, jp, src, alu, imm, pc;
        bit ok, alt;
        alu_map = '{0, 5, 8, 9, 4, 6, 3, 2};
        br_map  = '{1, 1, -1, -1, 8, 8, 9, 9};
        op = int'(ins[6:0]);
        f3 = int'(ins[14:12]);
        f7 = int'(ins[31:25]);
        alt = (f7 == 32);
        rw = 0; mtr = 0; mr = 0; mw = 0; br = 0; jp = 0; src = 0;
        alu = 0; imm = 0; pc = 0; ok = 1'b1;
        case (op)
            'h33: begin
                rw = 1; alu = alu_map[f3];
                ok = (f7 == 0) || (alt && (f3 == 0 || f3 == 5));
                if (alt && f3 == 0) alu = 1;
                if (alt && f3 == 5) alu = 7;
            end
            'h13: begin
                rw = 1; src = 1; alu = alu_map[f3];
                if (f3 == 1) ok = (f7 == 0);
                if (f3 == 5) begin
                    ok = (f7 == 0) || alt;
                    if (alt) alu = 7;
                end
            end
            'h03: begin rw = 1; mtr = 1; mr = 1; src = 1; ok = f3 inside {0, 1, 2, 4, 5}; end
            'h23: begin mw = 1; src = 1; imm = 1; ok = (f3 <= 2); end
            'h63: begin br = 1; imm = 2; alu = br_map[f3]; ok = (br_map[f3] >= 0); end
            'h6F: begin rw = 1; jp = 1; imm = 3; pc = 1; end
            'h67: begin rw = 1; jp = 1; src = 1; pc = 2; ok = (f3 == 0); end
            'h37: begin rw = 1; src = 1; alu = 10; imm = 4; end
            default: ok = 1'b0;
        endcase
        if (ok)
            c = 16'(rw + 2*mtr + 4*mr + 8*mw + 16*br + 32*jp + 64*src
                    + 128*alu + 2048*imm + 16384*pc);
        else
            c = '0;
        il = !ok;
    endfunction

    task automatic drive(input logic r, input logic [31:0] ins);
        logic [15:0] c;
        logic        il;
        @(negedge clk);
        rst = r;
        instruction = ins;
        model(ins, c, il);
        exp_ctrl  = r ? 16'h0000 : c;
        exp_ill   = r ? 1'b0 : il;
        exp_instr = ins;
        exp_valid = 1'b1;
    endtask

    task automatic pin(input string name, input logic [31:0] ins,
                       input logic [15:0] lit_ctrl, input logic lit_ill);
        logic [15:0] c;
        logic        il;
        model(ins, c, il);
        checks++;
        if (c !== lit_ctrl || il !== lit_ill) begin
            errors++;
            $display("FAIL model_%s instr=%h got ctrl=%h ill=%b want ctrl=%h ill=%b",
                     name, ins, c, il, lit_ctrl, lit_ill);
        end
        drive(1'b0, ins);
    endtask

    // Single compare process: the expectation captured at the edge is checked just after it.
    always @(posedge clk) begin
        logic        v;
        logic [15:0] ec;
        logic        ei;
        logic [31:0] ii;
        v = exp_valid; ec = exp_ctrl; ei = exp_ill; ii = exp_instr;
        #1;
        if (v) begin
            checks++;
            if (control_signals !== ec || illegal !== ei) begin
                errors++;
                $display("FAIL decode instr=%h got ctrl=%h ill=%b want ctrl=%h ill=%b",
                         ii, control_signals, illegal, ec, ei);
            end
        end
    end

    initial begin
        logic [6:0]  ops[11];
        logic [31:0] w;
        logic [6:0]  op, f7;
        ops = '{7'h33, 7'h13, 7'h03, 7'h23, 7'h63, 7'h6F, 7'h67, 7'h37, 7'h17, 7'h0F, 7'h73};
        rst = 1'b1;
        instruction = 32'h0000_0033;

        drive(1'b1, 32'h0000_0033);
        drive(1'b1, 32'h0000_0033);
        pin("add",  32'h0000_0033, 16'h0001, 1'b0);
        pin("sub",  32'h4000_0033, 16'h0081, 1'b0);
        pin("sra",  32'h4000_5033, 16'h0381, 1'b0);
        pin("addi", 32'h0000_0013, 16'h0041, 1'b0);
        pin("lw",   32'h0000_2003, 16'h0047, 1'b0);
        pin("sw",   32'h0000_2023, 16'h0848, 1'b0);
        pin("beq",  32'h0000_0063, 16'h1090, 1'b0);
        pin("jal",  32'h0000_006F, 16'h5821, 1'b0);
        pin("jalr", 32'h0000_0067, 16'h8061, 1'b0);
        pin("lui",  32'h1234_5037, 16'h2541, 1'b0);
        pin("addi_bit30", 32'h4000_0013, 16'h0041, 1'b0);
        pin("srai", 32'h4000_5013, 16'h03C1, 1'b0);
        pin("rd_x0_add", 32'h0000_0033, 16'h0001, 1'b0);
        pin("auipc", 32'h0000_0017, 16'h0000, 1'b1);
        pin("r_f7_1", 32'h0200_0033, 16'h0000, 1'b1);
        pin("sd",   32'h0000_3023, 16'h0000, 1'b1);
        pin("ones", 32'hFFFF_FFFF, 16'h0000, 1'b1);
        pin("b_f3_2", 32'h0000_2063, 16'h0000, 1'b1);
        pin("slli_bad", 32'h4000_1013, 16'h0000, 1'b1);
        drive(1'b1, 32'h0000_0033);
        pin("after_rst", 32'h4000_0033, 16'h0081, 1'b0);

        for (int n = 0; n < 3000; n++) begin
            int k;
            w = $urandom();
            k = $urandom_range(0, 11);
            op = (k == 11) ? 7'($urandom()) : ops[k];
            case ($urandom_range(0, 3))
                0:       f7 = 7'h00;
                1:       f7 = 7'h20;
                default: f7 = 7'($urandom());
            endcase
            drive($urandom_range(0, 31) == 0, {f7, w[24:7], op});
        end

        @(negedge clk);
        exp_valid = 1'b0;
        @(posedge clk);
        #2;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
